// File: rtl/ram32x4_ctrl_pkg.sv
// ram32x4_ctrl_pkg
//   Shared definitions for the 32x4 RAM command sequencer: RAM geometry,
//   command op codes and the controller state encoding.
//   No ports (package).
package ram32x4_ctrl_pkg;

    localparam int RAM_DEPTH = 32;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 4;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_FILL  = 2'b01;
    localparam logic [1:0] OP_SCAN  = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_FILL  = 3'd2,
        ST_SCAN  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

endpackage

// File: rtl/ram_addr_counter.sv
// ram_addr_counter
//   5-bit wrapping address counter shared by FILL and SCAN. A load restarts
//   the walk at load_value; each increment advances the address by one
//   (natural 5-bit wrap). 'last' is high once 31 increments have been taken
//   since the load, i.e. the 32nd address of the walk is being driven.
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-high reset
//   load        in   load load_value and restart the step count
//   load_value  in   5  start address
//   inc         in   advance address and step count
//   value       out  5  current address (registered)
//   last        out  final address of a 32-step walk is on value
module ram_addr_counter
    import ram32x4_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    input  logic              inc,
    output logic [ADDR_W-1:0] value,
    output logic              last
);

    logic [ADDR_W-1:0] steps;

    always_ff @(posedge clock) begin
        if (reset) begin
            value <= '0;
            steps <= '0;
        end else if (load) begin
            value <= load_value;
            steps <= '0;
        end else if (inc) begin
            value <= value + ADDR_W'(1);
            steps <= steps + ADDR_W'(1);
        end
    end

    assign last = (steps == ADDR_W'(RAM_DEPTH - 1));

endmodule

// File: rtl/ram32x4_ctrl.sv
// ram32x4_ctrl
//   Command sequencer in front of a 32x4 synchronous RAM. Executes one
//   command at a time: single WRITE, FILL of all 32 words with a pattern,
//   SCAN-read of all 32 words from a start address (wrapping), or NOP.
//   Scan words come back on rd_valid/rd_addr/rd_data; done pulses for one
//   cycle when a command completes.
//   Optional feature macro: RAM32X4_CTRL_CHECKSUM_EN adds a 9-bit 'checksum'
//   output holding the sum of the words returned by the most recent SCAN.
// Ports:
//   clock, reset          clock / synchronous active-high reset
//   cmd_valid, cmd_ready  command handshake
//   cmd_op[1:0]           00 WRITE, 01 FILL, 10 SCAN, 11 NOP
//   cmd_addr[4:0]         WRITE address / SCAN start address
//   cmd_data[3:0]         WRITE data / FILL pattern
//   ram_address[4:0], ram_data[3:0], ram_wren   registered RAM drive
//   ram_q[3:0]            RAM read data (one cycle after address sample)
//   rd_valid, rd_addr[4:0], rd_data[3:0]        scan result stream
//   busy                  !cmd_ready
//   done                  one-cycle completion pulse
//   checksum[8:0]         scan checksum (only with the macro)
//   dbg_state[2:0]        current controller state, for observation
//
// Handshake: a command is taken on the rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE, so commands
// presented while busy are simply not taken (no queueing), and cmd_* need
// only be stable on that accepting edge.
module ram32x4_ctrl
    import ram32x4_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
`ifdef RAM32X4_CTRL_CHECKSUM_EN
    output logic [8:0]        checksum,
`endif
    output logic [2:0]        dbg_state
);

    state_t            state;
    logic              accept;
    logic              cnt_load;
    logic              cnt_inc;
    logic              cnt_last;
    logic [ADDR_W-1:0] cnt_load_value;
    logic [ADDR_W-1:0] cnt_value;

    // One-stage tag pipeline matching the RAM read latency: the address
    // driven during a SCAN cycle is remembered here while the RAM samples
    // it, so rd_addr lines up with the ram_q that comes back a cycle later.
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;

    assign cmd_ready   = (state == ST_IDLE);
    assign busy        = !cmd_ready;
    assign accept      = cmd_valid && cmd_ready;
    assign dbg_state   = state;
    assign ram_address = cnt_value;

    always_comb begin
        cnt_load       = 1'b0;
        cnt_load_value = cmd_addr;
        cnt_inc        = 1'b0;
        if (accept && (cmd_op != OP_NOP)) begin
            cnt_load = 1'b1;
            if (cmd_op == OP_FILL) begin
                cnt_load_value = '0;
            end
        end
        // Walk the address until the 32nd one has been driven.
        if (((state == ST_FILL) || (state == ST_SCAN)) && !cnt_last) begin
            cnt_inc = 1'b1;
        end
    end

    ram_addr_counter u_addr_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .inc        (cnt_inc),
        .value      (cnt_value),
        .last       (cnt_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            ram_data   <= '0;
            ram_wren   <= 1'b0;
            rd_valid   <= 1'b0;
            rd_addr    <= '0;
            rd_data    <= '0;
            done       <= 1'b0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
        end else begin
            done       <= 1'b0;
            pend_valid <= (state == ST_SCAN);
            pend_addr  <= cnt_value;
            rd_valid   <= pend_valid;
            if (pend_valid) begin
                rd_addr <= pend_addr;
                rd_data <= ram_q;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_WRITE: begin
                                ram_data <= cmd_data;
                                ram_wren <= 1'b1;
                                state    <= ST_WRITE;
                            end
                            OP_FILL: begin
                                ram_data <= cmd_data;
                                ram_wren <= 1'b1;
                                state    <= ST_FILL;
                            end
                            OP_SCAN: begin
                                ram_wren <= 1'b0;
                                state    <= ST_SCAN;
                            end
                            default: begin
                                done <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_WRITE: begin
                    ram_wren <= 1'b0;
                    done     <= 1'b1;
                    state    <= ST_IDLE;
                end
                ST_FILL: begin
                    if (cnt_last) begin
                        ram_wren <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    // Last address has been issued; wait for its data.
                    if (cnt_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The final word is registered on this same edge.
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RAM32X4_CTRL_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            checksum <= '0;
        end else if (accept && (cmd_op == OP_SCAN)) begin
            checksum <= '0;
        end else if (pend_valid) begin
            checksum <= checksum + {5'd0, ram_q};
        end
    end
`endif

endmodule

// File: tb/tb_ram32x4_ctrl.sv
// tb_ram32x4_ctrl
//   Self-checking bench for ram32x4_ctrl. A behavioural 32x4 synchronous RAM
//   is attached to the controller; a separate reference memory tracks what
//   the RAM should hold according to the command semantics, and SCAN results
//   are checked against an expected queue built from that reference memory.
module tb_ram32x4_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [4:0] cmd_addr;
    logic [3:0] cmd_data;
    logic [4:0] ram_address;
    logic [3:0] ram_data;
    logic       ram_wren;
    logic [3:0] ram_q;
    logic       rd_valid;
    logic [4:0] rd_addr;
    logic [3:0] rd_data;
    logic       busy;
    logic       done;
    logic [2:0] dbg_state;
`ifdef RAM32X4_CTRL_CHECKSUM_EN
    logic [8:0] checksum;
`endif

    int errors = 0;
    int checks = 0;

    logic [3:0] mem     [32];
    logic [3:0] ref_mem [32];
    logic [8:0] exp_q[$];

    localparam logic [1:0] C_WRITE = 2'b00;
    localparam logic [1:0] C_FILL  = 2'b01;
    localparam logic [1:0] C_SCAN  = 2'b10;
    localparam logic [1:0] C_NOP   = 2'b11;

    // ---------------- clock / reset / environment ----------------
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    ram32x4_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q),
        .rd_valid    (rd_valid),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy),
        .done        (done),
`ifdef RAM32X4_CTRL_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .dbg_state   (dbg_state)
    );

    // ---------------- driver tasks ----------------
    // Called at a negedge. Presents a command, waits (bounded) for it to be
    // taken, and returns at the negedge right after the accepting edge E0.
    task automatic issue(input logic [1:0] op, input logic [4:0] addr, input logic [3:0] data);
        int waited = 0;
        while (!cmd_ready && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: cmd_ready=%0b expected 1 after %0d cycles", cmd_ready, waited);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_addr  = 5'($urandom);
        cmd_data  = 4'($urandom);
    endtask

    // Starts at the negedge after a FILL's E0; ends at the done cycle.
    task automatic watch_fill(input logic [3:0] p);
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (ram_wren !== 1'b1 || ram_address !== 5'(k) || ram_data !== p || done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL fill_step k=%0d: wren=%0b addr=%0d data=%h done=%0b busy=%0b, expected wren=1 addr=%0d data=%h done=0 busy=1",
                         k, ram_wren, ram_address, ram_data, done, busy, k, p);
            end
            @(negedge clock);
        end
        checks++;
        if (ram_wren !== 1'b0 || done !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_end: wren=%0b done=%0b ready=%0b, expected 0 1 1", ram_wren, done, cmd_ready);
        end
        for (int i = 0; i < 32; i++) ref_mem[i] = p;
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [3:0] data);
        issue(C_WRITE, addr, data);
        @(negedge clock);
        checks++;
        if (done !== 1'b1 || ram_wren !== 1'b0) begin
            errors++;
            $display("FAIL write_done: done=%0b wren=%0b, expected 1 0", done, ram_wren);
        end
        ref_mem[addr] = data;
    endtask

    // Scoreboard for one SCAN; ends at the done cycle.
    task automatic do_scan(input logic [4:0] start, output logic [4:0] first_addr, output logic [4:0] last_addr);
        int n_valid = 0;
        int exp_sum = 0;
        int done_k  = -1;
        bit saw_wren = 0;
        logic [4:0] a;
        logic [8:0] exp;
        first_addr = 'x;
        last_addr  = 'x;
        exp_q.delete();
        for (int k = 0; k < 32; k++) begin
            a = start + 5'(k);
            exp_q.push_back({a, ref_mem[a]});
            exp_sum += int'(ref_mem[a]);
        end
        issue(C_SCAN, start, 4'($urandom));
        for (int k = 0; k < 40 && done_k < 0; k++) begin
            if (ram_wren) saw_wren = 1;
            if (rd_valid === 1'b1) begin
                if (n_valid == 0) begin
                    checks++;
                    if (k != 2) begin
                        errors++;
                        $display("FAIL scan_latency: first rd_valid %0d cycles after E0, expected 2", k);
                    end
                    first_addr = rd_addr;
                end
                last_addr = rd_addr;
                n_valid++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scan_extra: rd_addr=%0d rd_data=%h, expected no more words", rd_addr, rd_data);
                end else begin
                    exp = exp_q.pop_front();
                    if ({rd_addr, rd_data} !== exp) begin
                        errors++;
                        $display("FAIL scan_word: addr=%0d data=%h, expected addr=%0d data=%h", rd_addr, rd_data, exp[8:4], exp[3:0]);
                    end
                end
            end
            if (done === 1'b1) done_k = k;
            else @(negedge clock);
        end
        checks++;
        if (done_k != 33 || rd_valid !== 1'b1 || n_valid != 32) begin
            errors++;
            $display("FAIL scan_done: done at cycle %0d rd_valid=%0b words=%0d, expected cycle 33 rd_valid=1 words=32",
                     done_k, rd_valid, n_valid);
        end
        checks++;
        if (saw_wren) begin
            errors++;
            $display("FAIL scan_wren: ram_wren=1 during scan, expected 0");
        end
`ifdef RAM32X4_CTRL_CHECKSUM_EN
        checks++;
        if (checksum !== 9'(exp_sum)) begin
            errors++;
            $display("FAIL scan_checksum: checksum=%0d expected %0d", checksum, exp_sum);
        end
`endif
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            cmd_valid = 1'($urandom);
            cmd_op    = 2'($urandom);
            cmd_addr  = 5'($urandom);
            cmd_data  = 4'($urandom);
        end
        @(negedge clock);
        checks++;
        if (ram_address !== 5'd0 || ram_data !== 4'd0 || ram_wren !== 1'b0 || rd_valid !== 1'b0 ||
            rd_addr !== 5'd0 || rd_data !== 4'd0 || done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: addr=%0d data=%h wren=%0b rd_valid=%0b rd_addr=%0d rd_data=%h done=%0b ready=%0b busy=%0b, expected all 0 except ready=1",
                     ram_address, ram_data, ram_wren, rd_valid, rd_addr, rd_data, done, cmd_ready, busy);
        end
`ifdef RAM32X4_CTRL_CHECKSUM_EN
        checks++;
        if (checksum !== 9'd0) begin
            errors++;
            $display("FAIL reset_checksum: checksum=%0d expected 0", checksum);
        end
`endif
        reset     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_write();
        issue(C_WRITE, 5'd17, 4'hC);
        checks++;
        if (ram_wren !== 1'b1 || ram_address !== 5'd17 || ram_data !== 4'hC || cmd_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL write_e0: wren=%0b addr=%0d data=%h ready=%0b done=%0b, expected 1 17 c 0 0",
                     ram_wren, ram_address, ram_data, cmd_ready, done);
        end
        @(negedge clock);
        checks++;
        if (ram_wren !== 1'b0 || done !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_e1: wren=%0b done=%0b ready=%0b, expected 0 1 1", ram_wren, done, cmd_ready);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || mem[17] !== 4'hC) begin
            errors++;
            $display("FAIL write_after: done=%0b mem[17]=%h, expected 0 c", done, mem[17]);
        end
        ref_mem[17] = 4'hC;
    endtask

    task automatic test_nop();
        issue(C_NOP, 5'($urandom), 4'($urandom));
        checks++;
        if (done !== 1'b1 || ram_wren !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL nop_e0: done=%0b wren=%0b ready=%0b, expected 1 0 1", done, ram_wren, cmd_ready);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || ram_wren !== 1'b0) begin
            errors++;
            $display("FAIL nop_after: done=%0b wren=%0b, expected 0 0", done, ram_wren);
        end
    endtask

    task automatic test_fill_scan();
        logic [4:0] fa, la;
        issue(C_FILL, 5'($urandom), 4'h5);
        watch_fill(4'h5);
        do_scan(5'd0, fa, la);
        checks++;
        if (fa !== 5'd0 || la !== 5'd31) begin
            errors++;
            $display("FAIL fill_scan_range: first=%0d last=%0d, expected 0 31", fa, la);
        end
`ifdef RAM32X4_CTRL_CHECKSUM_EN
        checks++;
        if (checksum !== 9'd160) begin
            errors++;
            $display("FAIL fill_scan_checksum: checksum=%0d expected 160", checksum);
        end
`endif
        @(negedge clock);
        checks++;
        if (rd_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL scan_after: rd_valid=%0b done=%0b, expected 0 0", rd_valid, done);
        end
    endtask

    task automatic test_scan_wrap();
        logic [4:0] fa, la;
        do_write(5'd31, 4'h3);
        do_write(5'd0, 4'h7);
        do_scan(5'd31, fa, la);
        checks++;
        if (fa !== 5'd31 || la !== 5'd30) begin
            errors++;
            $display("FAIL scan_wrap_range: first=%0d last=%0d, expected 31 30", fa, la);
        end
        @(negedge clock);
    endtask

    task automatic test_busy();
        logic [3:0] p = 4'($urandom);
        logic [4:0] wa = 5'($urandom);
        logic [3:0] wd = 4'($urandom);
        logic [4:0] fa, la;
        issue(C_FILL, 5'($urandom), p);
        // Hold a WRITE request throughout the FILL; it must wait for IDLE.
        cmd_valid = 1'b1;
        cmd_op    = C_WRITE;
        cmd_addr  = wa;
        cmd_data  = wd;
        watch_fill(p);
        @(negedge clock);
        cmd_valid = 1'b0;
        checks++;
        if (ram_wren !== 1'b1 || ram_address !== wa || ram_data !== wd) begin
            errors++;
            $display("FAIL busy_held_write: wren=%0b addr=%0d data=%h, expected 1 %0d %h", ram_wren, ram_address, ram_data, wa, wd);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL busy_held_done: done=%0b expected 1", done);
        end
        ref_mem[wa] = wd;
        do_scan(5'($urandom), fa, la);
        @(negedge clock);
    endtask

    task automatic test_reset_mid_fill();
        logic [4:0] fa, la;
        issue(C_FILL, 5'($urandom), 4'hA);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (ram_address !== 5'd0 || ram_data !== 4'd0 || ram_wren !== 1'b0 || rd_valid !== 1'b0 ||
            rd_addr !== 5'd0 || rd_data !== 4'd0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midfill_reset: addr=%0d data=%h wren=%0b rd_valid=%0b rd_addr=%0d rd_data=%h done=%0b ready=%0b, expected reset values",
                     ram_address, ram_data, ram_wren, rd_valid, rd_addr, rd_data, done, cmd_ready);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) ref_mem[i] = 4'hA;
        repeat (3) begin
            @(negedge clock);
            checks++;
            if (done !== 1'b0 || ram_wren !== 1'b0) begin
                errors++;
                $display("FAIL midfill_quiet: done=%0b wren=%0b, expected 0 0", done, ram_wren);
            end
        end
        do_scan(5'd0, fa, la);
        @(negedge clock);
    endtask

    task automatic test_random();
        logic [4:0] fa, la;
        repeat (6) begin
            repeat ($urandom_range(1, 4)) begin
                if ($urandom_range(0, 3) == 0) begin
                    issue(C_NOP, 5'($urandom), 4'($urandom));
                end else begin
                    do_write(5'($urandom), 4'($urandom));
                end
            end
            do_scan(5'($urandom), fa, la);
        end
        @(negedge clock);
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = 5'd0;
        cmd_data  = 4'd0;
        // Known initial RAM contents that never equal 0xA, so a FILL that
        // runs past its reset point would show up in the mid-FILL test.
        for (int i = 0; i < 32; i++) begin
            mem[i]     = 4'($urandom_range(0, 9));
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_write();
        test_nop();
        test_fill_scan();
        test_scan_wrap();
        test_busy();
        test_reset_mid_fill();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram32x4_ctrl.md
# ram32x4_ctrl

Command sequencer that sits directly upstream of the 32x4 synchronous RAM and drives its address, data and write-enable inputs. It accepts one command at a time over a valid/ready handshake: single write, fill all 32 words, or scan-read all 32 words. It returns scan results as a read-data stream and pulses `done` when each command completes. The RAM is instantiated alongside it at the lab top level; this block only consumes its `q` output.

## Interface
- No parameters; geometry is fixed at 32 words × 4 bits.
- `clock`  in  1  single clock, rising edge; also feeds the RAM `clock`.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high exactly while in IDLE (combinational from state).
- `cmd_op`  in  2  00 WRITE, 01 FILL, 10 SCAN, 11 NOP.
- `cmd_addr`  in  5  WRITE target address / SCAN start address; ignored for FILL and NOP.
- `cmd_data`  in  4  WRITE data / FILL pattern.
- `ram_address`  out  5  registered.
- `ram_data`  out  4  registered.
- `ram_wren`  out  1  registered.
- `ram_q`  in  4  RAM read data; valid one cycle after the edge that samples the address.
- `rd_valid`  out  1  registered; scan word valid.
- `rd_addr`  out  5  address of `rd_data`.
- `rd_data`  out  4  scanned word.
- `busy`  out  1  equal to `!cmd_ready`.
- `done`  out  1  one-cycle completion pulse.
- `checksum`  out  9  present only with `RAM32X4_CTRL_CHECKSUM_EN`.

## Operation
- States: IDLE, WRITE, FILL, SCAN, DRAIN.
- Accept on an edge where `cmd_valid && cmd_ready`; call that edge E0.
- WRITE
  - At E0: `ram_address<=cmd_addr`, `ram_data<=cmd_data`, `ram_wren<=1`.
  - At E1: the RAM writes; `ram_wren<=0`, `done<=1`, go to IDLE.
- FILL
  - At E0: `ram_address<=0`, `ram_data<=cmd_data`, `ram_wren<=1`.
  - Each following edge increments `ram_address`.
  - Address 31 is driven after E31 and written at E32.
  - At E32: `ram_wren<=0`, `done<=1`, go to IDLE.
- SCAN
  - At E0: `ram_address<=cmd_addr`, `ram_wren<=0`.
  - The address driven after E_k is `(cmd_addr+k) mod 32`, for k = 0..31. Wrap-around is natural 5-bit overflow.
  - At E_{k+2} the block registers `rd_valid<=1`, `rd_addr<=cmd_addr+k`, `rd_data<=ram_q`.
  - Enter DRAIN at E32, after the last address has been issued.
  - At E33: last word out, `done<=1` in the same cycle as the last `rd_valid`, go to IDLE.
- NOP: state stays IDLE; `done<=1` at E0; no RAM activity.
- `rd_valid` is high for exactly 32 consecutive cycles per SCAN and never outside SCAN/DRAIN.
- The bench checks `done` and `rd_valid`; the top level may ignore them.

## Timing
- Reset values: `ram_address=0`, `ram_data=0`, `ram_wren=0`, `rd_valid=0`, `rd_addr=0`, `rd_data=0`, `done=0`, `checksum=0`, state IDLE (so `cmd_ready=1`).
- Busy durations from E0: WRITE 1 cycle, FILL 32 cycles, SCAN 33 cycles, NOP 0 cycles.
- First SCAN data appears 2 cycles after E0.
- Back-to-back commands: a new command can be accepted on the edge right after `done` is registered.
- `cmd_*` is sampled only at E0 and may change afterwards.
- Reset mid-operation:
  - The RAM samples the pre-reset `ram_wren`, so a write already issued completes at the reset edge.
  - No further writes occur; partial FILL contents remain in the RAM.
  - No `done` pulse is produced for the aborted command.
- `cmd_valid` while busy is ignored; no queuing.

## Configuration
- `RAM32X4_CTRL_CHECKSUM_EN` defined:
  - `checksum` is cleared to 0 at SCAN E0.
  - It adds `{5'd0, ram_q}` on each edge that sets `rd_valid`.
  - It is final and stable from the `done` cycle until the next SCAN accept. Maximum value is 480, so it fits in 9 bits without overflow.
- Undefined: the `checksum` port and its logic are absent.

## Structure
- Package `ram32x4_ctrl_pkg` holds:
  - op codes `OP_WRITE`, `OP_FILL`, `OP_SCAN`, `OP_NOP`;
  - the state enum;
  - constants `RAM_DEPTH=32`, `ADDR_W=5`, `DATA_W=4`.
- One sub-module is natural: `ram_addr_counter`, a 5-bit wrapping counter with load, increment and terminal-count-after-32-steps outputs. It is shared by FILL and SCAN.

## Test plan
- Reset mid-FILL: FILL pattern 0xA, then reset 10 cycles after E0 → outputs return to reset values; a following SCAN start 0 shows addresses 0–9 = 0xA and 10–31 unchanged.
- FILL then full SCAN: FILL pattern 0x5, then SCAN start 0 → 32 `rd_valid` cycles, each `rd_data=5`, `rd_addr` 0..31. `done` coincides with the last word. With the macro, `checksum=160`.
- SCAN wrap: WRITE 0x3→addr 31 and 0x7→addr 0, then SCAN start 31 → first word is (31,3), second (0,7), last `rd_addr=30`.
- WRITE latency: WRITE 0xC→addr 17 → `ram_wren` high exactly 1 cycle with `ram_address=17`; `done` the next cycle; `cmd_ready` back 1 cycle after E0.
- Busy/NOP: `cmd_valid` held high during FILL is not accepted until `cmd_ready`; NOP gives `done` the cycle after E0 and no `ram_wren`.
